// File: rtl/iana_trace_buf.sv
// Elastic trace buffer between the CPU trace port and the dma_ctrl write port.
// Absorbs records while DMA is not writable and asks the CPU to stall with hysteresis.
module iana_trace_buf #(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic                     clock2,
    input  logic                     nreset,
    input  logic                     trace_en,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_we,
    input  logic                     out_writable,
    output logic                     stall_req,
    output logic                     stall_release,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_cnt,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_we_q, out_we_d;
    logic              stall_req_q, stall_req_d;
    logic              stall_release_q, stall_release_d;
    state_t            state_q, state_d;
    logic              push_req_s, push_s, pop_s, drop_s;

    // Push/pop qualification; a full FIFO still accepts when a pop frees a slot on the same edge.
    always_comb begin
        push_req_s = in_valid & trace_en & ~flush;
        pop_s      = (level_q != {LVL_W{1'b0}}) & out_writable & ~flush;
        push_s     = push_req_s & ((level_q < LVL_W'(DEPTH)) | pop_s);
        drop_s     = push_req_s & ~push_s;
    end

    // Datapath next-state: pointers, occupancy, output record, drop accounting.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        out_we_d   = 1'b0;
        out_data_d = out_data_q;
        if (flush) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            level_d    = {LVL_W{1'b0}};
            drop_cnt_d = 16'h0000;
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                out_we_d   = 1'b1;
                out_data_d = mem_q[rd_ptr_q];
            end else begin
                rd_ptr_d   = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop_s && !push_s) begin
                level_d = level_q - LVL_W'(1);
            end else begin
                level_d = level_q;
            end
            if (drop_s) begin
                overflow_d = 1'b1;
                drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? 16'hFFFF : drop_cnt_q + 16'h0001;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Stall hysteresis FSM, evaluated on the occupancy the FIFO will have after this edge.
    always_comb begin
        state_d         = state_q;
        stall_req_d     = stall_req_q;
        stall_release_d = 1'b0;
        if (flush) begin
            state_d         = ST_RUN;
            stall_req_d     = 1'b0;
            stall_release_d = stall_req_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (level_d >= LVL_W'(AFULL_TH)) begin
                        state_d     = ST_HOLD;
                        stall_req_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (level_d <= LVL_W'(AEMPTY_TH)) begin
                        state_d         = ST_RUN;
                        stall_req_d     = 1'b0;
                        stall_release_d = 1'b1;
                    end else begin
                        state_d         = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    stall_req_d = 1'b0;
                end
            endcase
        end
    end

    // Record storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock2) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock2 or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q        <= {PTR_W{1'b0}};
            rd_ptr_q        <= {PTR_W{1'b0}};
            level_q         <= {LVL_W{1'b0}};
            drop_cnt_q      <= 16'h0000;
            overflow_q      <= 1'b0;
            out_data_q      <= {DATA_W{1'b0}};
            out_we_q        <= 1'b0;
            stall_req_q     <= 1'b0;
            stall_release_q <= 1'b0;
            state_q         <= ST_RUN;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            drop_cnt_q      <= drop_cnt_d;
            overflow_q      <= overflow_d;
            out_data_q      <= out_data_d;
            out_we_q        <= out_we_d;
            stall_req_q     <= stall_req_d;
            stall_release_q <= stall_release_d;
            state_q         <= state_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_we        = out_we_q;
    assign stall_req     = stall_req_q;
    assign stall_release = stall_release_q;
    assign level         = level_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_iana_trace_buf.sv
// Directed self-checking bench for iana_trace_buf.
module tb_iana_trace_buf;
    logic         clock2;
    logic         nreset;
    logic         trace_en;
    logic         flush;
    logic [127:0] in_data;
    logic         in_valid;
    logic [127:0] out_data;
    logic         out_we;
    logic         out_writable;
    logic         stall_req;
    logic         stall_release;
    logic [4:0]   level;
    logic [15:0]  drop_cnt;
    logic         overflow;

    int checks;
    int failures;

    iana_trace_buf dut (
        .clock2        (clock2),
        .nreset        (nreset),
        .trace_en      (trace_en),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_we        (out_we),
        .out_writable  (out_writable),
        .stall_req     (stall_req),
        .stall_release (stall_release),
        .level         (level),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    initial clock2 = 1'b0;
    always #5 clock2 = ~clock2;

    function automatic logic [127:0] rec(input int n);
        rec = {32'(n), 32'hC0DE_F00D, 32'(~n), 32'(n * 3)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock2);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        nreset       = 1'b0;
        trace_en     = 1'b0;
        flush        = 1'b0;
        in_data      = 128'd0;
        in_valid     = 1'b0;
        out_writable = 1'b0;
        #23;
        chk("rst_out_we",   128'(out_we),        128'(1'b0));
        chk("rst_out_data", out_data,            128'd0);
        chk("rst_level",    128'(level),         128'(5'd0));
        chk("rst_stall",    128'(stall_req),     128'(1'b0));
        chk("rst_release",  128'(stall_release), 128'(1'b0));
        chk("rst_drop",     128'(drop_cnt),      128'(16'd0));
        chk("rst_ovf",      128'(overflow),      128'(1'b0));
        nreset = 1'b1;
        tick();

        // 1: streaming with DMA writable
        trace_en     = 1'b1;
        out_writable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data  = rec(i);
            in_valid = 1'b1;
            tick();
            if (i == 1) begin
                chk("t1_first_we",    128'(out_we), 128'(1'b0));
                chk("t1_first_level", 128'(level),  128'(5'd1));
            end else begin
                chk("t1_we",    128'(out_we), 128'(1'b1));
                chk("t1_data",  out_data,     rec(i - 1));
                chk("t1_level", 128'(level),  128'(5'd1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("t1_last_we",   128'(out_we), 128'(1'b1));
        chk("t1_last_data", out_data,     rec(5));
        chk("t1_empty",     128'(level),  128'(5'd0));
        tick();
        chk("t1_we_off",    128'(out_we), 128'(1'b0));
        chk("t1_data_hold", out_data,     rec(5));

        // 2: stall hysteresis
        out_writable = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            in_data  = rec(100 + i);
            in_valid = 1'b1;
            tick();
            chk("t2_fill_level", 128'(level),     128'(i));
            chk("t2_fill_stall", 128'(stall_req), 128'(i == 12));
        end
        in_valid     = 1'b0;
        out_writable = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("t2_drain_data",  out_data,            rec(100 + j));
            chk("t2_drain_level", 128'(level),         128'(12 - j));
            chk("t2_stall",       128'(stall_req),     128'((12 - j) > 4));
            chk("t2_release",     128'(stall_release), 128'(j == 8));
        end
        tick();
        chk("t2_we_off", 128'(out_we), 128'(1'b0));

        // 3: overflow and drop accounting
        out_writable = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            in_data  = rec(200 + i);
            in_valid = 1'b1;
            tick();
            if (i == 16) begin
                chk("t3_full_drop", 128'(drop_cnt), 128'(16'd0));
                chk("t3_full_ovf",  128'(overflow), 128'(1'b0));
            end
        end
        in_valid = 1'b0;
        chk("t3_level", 128'(level),    128'(5'd16));
        chk("t3_drop",  128'(drop_cnt), 128'(16'd4));
        chk("t3_ovf",   128'(overflow), 128'(1'b1));
        out_writable = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("t3_order", out_data,     rec(200 + j));
            chk("t3_we",    128'(out_we), 128'(1'b1));
        end
        tick();
        chk("t3_empty", 128'(level), 128'(5'd0));

        // 4: push and pop together at full
        out_writable = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_data  = rec(300 + i);
            in_valid = 1'b1;
            tick();
        end
        in_data      = rec(399);
        out_writable = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_level", 128'(level),    128'(5'd16));
        chk("t4_drop",  128'(drop_cnt), 128'(16'd4));
        chk("t4_data",  out_data,       rec(301));
        for (int j = 2; j <= 17; j++) begin
            tick();
            chk("t4_order", out_data, (j <= 16) ? rec(300 + j) : rec(399));
        end
        tick();
        chk("t4_empty", 128'(level), 128'(5'd0));

        // 5: flush while holding the CPU
        out_writable = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            in_data  = rec(400 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid     = 1'b0;
        out_writable = 1'b1;
        tick();
        tick();
        chk("t5_pre_level", 128'(level),     128'(5'd10));
        chk("t5_pre_stall", 128'(stall_req), 128'(1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_level",   128'(level),         128'(5'd0));
        chk("t5_we",      128'(out_we),        128'(1'b0));
        chk("t5_stall",   128'(stall_req),     128'(1'b0));
        chk("t5_release", 128'(stall_release), 128'(1'b1));
        chk("t5_drop",    128'(drop_cnt),      128'(16'd0));
        chk("t5_ovf",     128'(overflow),      128'(1'b0));
        tick();
        chk("t5_release_off", 128'(stall_release), 128'(1'b0));
        chk("t5_we_off",      128'(out_we),        128'(1'b0));

        // 6: async reset mid-drain
        out_writable = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data  = rec(500 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid     = 1'b0;
        out_writable = 1'b1;
        tick();
        chk("t6_pre_level", 128'(level),  128'(5'd7));
        chk("t6_pre_we",    128'(out_we), 128'(1'b1));
        #2;
        nreset = 1'b0;
        #1;
        chk("t6_rst_we",    128'(out_we),    128'(1'b0));
        chk("t6_rst_data",  out_data,        128'd0);
        chk("t6_rst_level", 128'(level),     128'(5'd0));
        chk("t6_rst_stall", 128'(stall_req), 128'(1'b0));
        #3;
        nreset = 1'b1;
        tick();
        chk("t6_post_we",    128'(out_we), 128'(1'b0));
        chk("t6_post_level", 128'(level),  128'(5'd0));
        tick();
        chk("t6_post_we2",   128'(out_we), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
